pc_redirect_unit: RTL and testbench

- Execute-stage control-flow resolver for the uP16 5-stage pipeline.
- Evaluates branch/jump conditions for the instruction in EX and computes its target.
- Drives the fetch stage's sel_PC/alt_PC redirect inputs and squashes wrong-path instructions in IF/ID.
- Sits opposite the fetch stage on the PC-redirect interface; fetch consumes what this block produces.

---
 rtl/uP16_pkg.sv | 22 ++
 rtl/branch_cond.sv | 32 +++
 rtl/pc_redirect_unit.sv | 141 ++++++++++++++
 tb/tb_pc_redirect_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uP16_pkg.sv
// Shared uP16 definitions: branch type encodings, redirect FSM states and
// the default datapath width.
package uP16_pkg;

  localparam int DSIZE_DEFAULT = 16;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_J    = 3'd4,
    BR_JR   = 3'd5
  } br_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDIR  = 2'd1,
    SQUASH = 2'd2
  } state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator; J/JR are unconditionally taken,
// NONE and the reserved encodings 6/7 are never taken.
module branch_cond
  import uP16_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEFAULT
) (
  input  logic [2:0]       br_type,
  input  logic [DSIZE-1:0] rs,
  input  logic [DSIZE-1:0] rt,
  output logic             taken
);

  logic signed [DSIZE-1:0] rs_s;
  logic signed [DSIZE-1:0] rt_s;

  assign rs_s = $signed(rs);
  assign rt_s = $signed(rt);

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = (rs == rt);
      BR_BNE:  taken = (rs != rt);
      BR_BLT:  taken = (rs_s < rt_s);
      BR_J:    taken = 1'b1;
      BR_JR:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// EX-stage control-flow resolver driving fetch redirect and IF/ID squash.
// Optional BRANCH_STATS_EN adds saturating resolved/taken branch counters.
module pc_redirect_unit
  import uP16_pkg::*;
#(
  parameter int DSIZE        = DSIZE_DEFAULT,
  parameter int OFF_W        = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic [2:0]       br_type,
  input  logic [DSIZE-1:0] ex_PCplus1,
  input  logic [OFF_W-1:0] offset,
  input  logic [DSIZE-1:0] jimm,
  input  logic [DSIZE-1:0] rs_data,
  input  logic [DSIZE-1:0] rt_data,
  output logic             sel_PC,
  output logic [DSIZE-1:0] alt_PC,
  output logic             flush_IF,
  output logic             flush_ID,
  output logic             busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]      br_resolved_cnt,
  output logic [15:0]      br_taken_cnt
`endif
);

  localparam logic [1:0] FLUSH_N = 2'(FLUSH_CYCLES);

  function automatic logic signed [DSIZE-1:0] sext_off(input logic signed [OFF_W-1:0] off);
    return {{(DSIZE-OFF_W){off[OFF_W-1]}}, off};
  endfunction

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [DSIZE-1:0]        alt_q, alt_d;
  logic                    cond_taken;
  logic                    accept;
  logic signed [DSIZE-1:0] br_target;
  logic [DSIZE-1:0]        target;

  branch_cond #(.DSIZE(DSIZE)) u_branch_cond (
    .br_type (br_type),
    .rs      (rs_data),
    .rt      (rt_data),
    .taken   (cond_taken)
  );

  assign accept    = (state_q == IDLE) && ex_valid && !stall;
  assign br_target = $signed(ex_PCplus1) + sext_off($signed(offset));

  always_comb begin
    target = $unsigned(br_target);
    case (br_type)
      BR_J:    target = jimm;
      BR_JR:   target = rs_data;
      default: target = $unsigned(br_target);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    alt_d   = alt_q;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (ex_valid && cond_taken) begin
            state_d = REDIR;
            alt_d   = target;
            cnt_d   = 2'd1;
          end
        end
        REDIR: begin
          if (FLUSH_CYCLES > 1) begin
            state_d = SQUASH;
            cnt_d   = 2'd2;
          end else begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end
        SQUASH: begin
          // cnt_q is the index of the flush cycle currently being shown
          if (cnt_q >= FLUSH_N) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      alt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alt_q   <= alt_d;
    end
  end

  assign sel_PC   = (state_q == REDIR);
  assign flush_IF = (state_q != IDLE);
  assign flush_ID = (state_q != IDLE);
  assign busy     = (state_q != IDLE);
  assign alt_PC   = alt_q;

`ifdef BRANCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic is_branch;
  assign is_branch = (br_type >= BR_BEQ) && (br_type <= BR_JR);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      br_resolved_cnt <= 16'd0;
      br_taken_cnt    <= 16'd0;
    end else if (accept) begin
      if (is_branch)  br_resolved_cnt <= sat_inc(br_resolved_cnt);
      if (cond_taken) br_taken_cnt    <= sat_inc(br_taken_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: fixed vectors, hand-written corner sequences
// and a randomized run against a flush-window reference model.
module tb_pc_redirect_unit;

  localparam int DSIZE = 16;
  localparam int OFF_W = 8;
  localparam int FC    = 2;

  logic              Clk;
  logic              Rst;
  logic              ex_valid;
  logic              stall;
  logic [2:0]        br_type;
  logic [DSIZE-1:0]  ex_PCplus1;
  logic [OFF_W-1:0]  offset;
  logic [DSIZE-1:0]  jimm;
  logic [DSIZE-1:0]  rs_data;
  logic [DSIZE-1:0]  rt_data;
  logic              sel_PC;
  logic [DSIZE-1:0]  alt_PC;
  logic              flush_IF;
  logic              flush_ID;
  logic              busy;
`ifdef BRANCH_STATS_EN
  logic [15:0]       br_resolved_cnt;
  logic [15:0]       br_taken_cnt;
`endif

  pc_redirect_unit #(.DSIZE(DSIZE), .OFF_W(OFF_W), .FLUSH_CYCLES(FC)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .ex_valid        (ex_valid),
    .stall           (stall),
    .br_type         (br_type),
    .ex_PCplus1      (ex_PCplus1),
    .offset          (offset),
    .jimm            (jimm),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .sel_PC          (sel_PC),
    .alt_PC          (alt_PC),
    .flush_IF        (flush_IF),
    .flush_ID        (flush_ID),
    .busy            (busy)
`ifdef BRANCH_STATS_EN
    ,
    .br_resolved_cnt (br_resolved_cnt),
    .br_taken_cnt    (br_taken_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a redirect opens a window of FC unstalled flush cycles,
  // the first of which also carries sel_PC.
  int          m_flush_left = 0;
  int          m_sel_left   = 0;
  logic [15:0] m_alt        = 16'h0;
  int          m_res        = 0;
  int          m_tak        = 0;

  function automatic int to_s16(input logic [15:0] v);
    return (v > 16'h7FFF) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic bit m_taken(input logic [2:0] bt, input logic [15:0] a, input logic [15:0] b);
    case (bt)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return to_s16(a) < to_s16(b);
      3'd4:    return 1'b1;
      3'd5:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] m_target(input logic [2:0] bt, input logic [15:0] pc1,
                                           input logic [7:0] off, input logic [15:0] ji,
                                           input logic [15:0] rs);
    int t;
    if (bt == 3'd4) return ji;
    if (bt == 3'd5) return rs;
    t = int'(pc1) + ((off > 8'd127) ? int'(off) - 256 : int'(off));
    return 16'(t);
  endfunction

  task automatic model_clk();
    if (Rst) begin
      m_flush_left = 0;
      m_sel_left   = 0;
      m_alt        = 16'h0;
      m_res        = 0;
      m_tak        = 0;
    end else if (!stall) begin
      if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_sel_left > 0) m_sel_left--;
      end else if (ex_valid) begin
        if (br_type >= 3'd1 && br_type <= 3'd5 && m_res < 65535) m_res++;
        if (m_taken(br_type, rs_data, rt_data)) begin
          if (m_tak < 65535) m_tak++;
          m_flush_left = FC;
          m_sel_left   = 1;
          m_alt        = m_target(br_type, ex_PCplus1, offset, jimm, rs_data);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_clk();
    #1;
  endtask

  task automatic set_br(input logic [2:0] bt, input logic [15:0] rs, input logic [15:0] rt,
                        input logic [15:0] pc1, input logic [7:0] off, input logic [15:0] ji);
    br_type = bt; rs_data = rs; rt_data = rt; ex_PCplus1 = pc1; offset = off; jimm = ji;
  endtask

  typedef struct {
    logic [2:0]  bt;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [15:0] pc1;
    logic [7:0]  off;
    logic [15:0] ji;
    logic        exp_sel;
    logic [15:0] exp_alt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'd1, 16'h0042, 16'h0042, 16'h0010, 8'hFC, 16'h0000, 1'b1, 16'h000C};
    vecs[1] = '{3'd2, 16'h0005, 16'h0005, 16'h0010, 8'h04, 16'h0000, 1'b0, 16'h0000};
    vecs[2] = '{3'd3, 16'hFFFF, 16'h0001, 16'h0100, 8'h10, 16'h0000, 1'b1, 16'h0110};
    vecs[3] = '{3'd3, 16'hFFFF, 16'h0001, 16'hFFFE, 8'h05, 16'h0000, 1'b1, 16'h0003};
    vecs[4] = '{3'd5, 16'h1234, 16'h0000, 16'h0020, 8'h00, 16'h0000, 1'b1, 16'h1234};
    vecs[5] = '{3'd4, 16'h0000, 16'h0001, 16'h0020, 8'h00, 16'hABCD, 1'b1, 16'hABCD};
    vecs[6] = '{3'd3, 16'h0001, 16'hFFFF, 16'h0020, 8'h04, 16'h0000, 1'b0, 16'h0000};
    vecs[7] = '{3'd1, 16'h0001, 16'h0002, 16'h0020, 8'h04, 16'h0000, 1'b0, 16'h0000};
    vecs[8] = '{3'd6, 16'h0007, 16'h0007, 16'h0020, 8'h04, 16'h5555, 1'b0, 16'h0000};
    vecs[9] = '{3'd2, 16'h0003, 16'h0004, 16'h0005, 8'h80, 16'h0000, 1'b1, 16'hFF85};

    Rst = 1'b0; ex_valid = 1'b0; stall = 1'b0;
    set_br(3'd0, 16'h0, 16'h0, 16'h0, 8'h0, 16'h0);

    // Reset while stalled with a taken BEQ pending
    Rst = 1'b1; stall = 1'b1; ex_valid = 1'b1;
    set_br(3'd1, 16'h0042, 16'h0042, 16'h0010, 8'hFC, 16'h0);
    step();
    chk("rst_sel", 32'(sel_PC), 32'd0);
    chk("rst_alt", 32'(alt_PC), 32'd0);
    chk("rst_flush_IF", 32'(flush_IF), 32'd0);
    chk("rst_flush_ID", 32'(flush_ID), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    Rst = 1'b0;
    step();
    chk("stall_no_accept_sel", 32'(sel_PC), 32'd0);
    chk("stall_no_accept_busy", 32'(busy), 32'd0);
    stall = 1'b0; ex_valid = 1'b0;
    step();

    // Fixed vectors, each presented for one cycle from IDLE
    for (int i = 0; i < 10; i++) begin
      set_br(vecs[i].bt, vecs[i].rs, vecs[i].rt, vecs[i].pc1, vecs[i].off, vecs[i].ji);
      ex_valid = 1'b1;
      step();
      ex_valid = 1'b0;
      chk($sformatf("vec%0d_sel", i), 32'(sel_PC), 32'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_sel));
      if (vecs[i].exp_sel) chk($sformatf("vec%0d_alt", i), 32'(alt_PC), 32'(vecs[i].exp_alt));
      for (int k = 0; k < FC + 1; k++) step();
    end

    // Flush window shape for a taken BEQ
    set_br(3'd1, 16'h0042, 16'h0042, 16'h0010, 8'hFC, 16'h0);
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    chk("win_c1_sel", 32'(sel_PC), 32'd1);
    chk("win_c1_flush", 32'({flush_IF, flush_ID}), 32'd3);
    step();
    chk("win_c2_sel", 32'(sel_PC), 32'd0);
    chk("win_c2_flush", 32'({flush_IF, flush_ID}), 32'd3);
    chk("win_c2_alt", 32'(alt_PC), 32'h000C);
    step();
    chk("win_c3_flush", 32'({flush_IF, flush_ID}), 32'd0);
    chk("win_c3_busy", 32'(busy), 32'd0);

    // J, then wrong-path BEQs while stalled in REDIR and while squashing
    set_br(3'd4, 16'h0, 16'h1, 16'h0030, 8'h00, 16'h4321);
    ex_valid = 1'b1;
    step();
    chk("j_sel", 32'(sel_PC), 32'd1);
    chk("j_alt", 32'(alt_PC), 32'h4321);
    set_br(3'd1, 16'h0009, 16'h0009, 16'h0100, 8'h04, 16'h0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("j_stall%0d_sel", k), 32'(sel_PC), 32'd1);
      chk($sformatf("j_stall%0d_alt", k), 32'(alt_PC), 32'h4321);
    end
    stall = 1'b0;
    step();
    chk("j_squash_sel", 32'(sel_PC), 32'd0);
    chk("j_squash_flush", 32'({flush_IF, flush_ID}), 32'd3);
    chk("j_squash_alt", 32'(alt_PC), 32'h4321);
    step();
    chk("j_done_flush", 32'({flush_IF, flush_ID}), 32'd0);
    ex_valid = 1'b0;
    step();
    chk("j_ignored_sel", 32'(sel_PC), 32'd0);
    chk("j_ignored_alt", 32'(alt_PC), 32'h4321);

    // Reset while squashing
    set_br(3'd5, 16'h2222, 16'h0, 16'h0, 8'h0, 16'h0);
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    step();
    chk("sq_pre_flush", 32'(flush_IF), 32'd1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("sq_rst_flush", 32'({flush_IF, flush_ID}), 32'd0);
    chk("sq_rst_busy", 32'(busy), 32'd0);
    chk("sq_rst_alt", 32'(alt_PC), 32'd0);

`ifdef BRANCH_STATS_EN
    // Three resolved branches, two taken
    set_br(3'd1, 16'h1, 16'h1, 16'h10, 8'h2, 16'h0); ex_valid = 1'b1; step(); ex_valid = 1'b0;
    for (int k = 0; k < FC; k++) step();
    set_br(3'd2, 16'h5, 16'h5, 16'h10, 8'h2, 16'h0); ex_valid = 1'b1; step(); ex_valid = 1'b0;
    set_br(3'd3, 16'hFFFF, 16'h1, 16'h10, 8'h2, 16'h0); ex_valid = 1'b1; step(); ex_valid = 1'b0;
    for (int k = 0; k < FC; k++) step();
    chk("stats_resolved", 32'(br_resolved_cnt), 32'd3);
    chk("stats_taken", 32'(br_taken_cnt), 32'd2);
`endif

    // Randomized run against the model
    for (int n = 0; n < 600; n++) begin
      Rst      = ($urandom_range(0, 49) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      ex_valid = ($urandom_range(0, 9) < 7);
      br_type  = 3'($urandom_range(0, 7));
      rs_data  = 16'($urandom);
      rt_data  = ($urandom_range(0, 2) == 0) ? rs_data : 16'($urandom);
      ex_PCplus1 = 16'($urandom);
      offset   = 8'($urandom);
      jimm     = 16'($urandom);
      step();
      chk("rnd_sel", 32'(sel_PC), 32'(m_sel_left > 0));
      chk("rnd_alt", 32'(alt_PC), 32'(m_alt));
      chk("rnd_flush_IF", 32'(flush_IF), 32'(m_flush_left > 0));
      chk("rnd_flush_ID", 32'(flush_ID), 32'(m_flush_left > 0));
      chk("rnd_busy", 32'(busy), 32'(m_flush_left > 0));
`ifdef BRANCH_STATS_EN
      chk("rnd_resolved", 32'(br_resolved_cnt), 32'(m_res));
      chk("rnd_taken", 32'(br_taken_cnt), 32'(m_tak));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
